// File: rtl/chart_sequencer.sv
// Chart sequencer: walks a note-chart ROM in step with the video frame tick.
// Every chart entry whose timestamp is due is merged into a single spawn
// pulse for the arrow block.
//
// state | meaning
// IDLE  | waiting for start, nothing played yet
// FETCH | ROM address presented, waiting one cycle for rom_data
// CHECK | evaluate current entry: end marker, due, or in the future
// WAIT  | next entry is in the future, wait for a counted frame tick
// DONE  | chart finished, done held until start or reset
module chart_sequencer #(
    parameter int          ROM_AW   = 8,
    parameter logic [15:0] END_WORD = 16'hFFF0
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              frame_clk,
    input  logic              start,
    input  logic              pause,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              spawn,
    output logic [3:0]        spawn_lanes,
    output logic [11:0]       frame_count,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CHECK,
        WAIT,
        DONE
    } state_t;

    localparam logic [11:0] FRAME_MAX = 12'hFFE;

    state_t            state;
    state_t            state_nxt;
    logic [ROM_AW-1:0] addr_nxt;
    logic [3:0]        acc;
    logic [3:0]        acc_nxt;
    logic              frame_clk_q;
    logic              frame_tick;
    logic              tick_counted;
    logic              restart;
    logic              spawn_c;
    logic [3:0]        lanes_c;
    logic [3:0]        merged;
    logic [11:0]       entry_ts;
    logic [3:0]        entry_mask;

    assign entry_ts     = rom_data[15:4];
    assign entry_mask   = rom_data[3:0];
    assign merged       = acc | entry_mask;
    assign frame_tick   = frame_clk & ~frame_clk_q;
    assign busy         = (state != IDLE) && (state != DONE);
    assign done         = (state == DONE);
    assign tick_counted = frame_tick & busy & ~pause;
    assign restart      = start && !busy;

    // Spawn is combinational out of CHECK; reset masks it so nothing leaks
    // out in the cycle reset is applied.
    assign spawn       = spawn_c & ~reset;
    assign spawn_lanes = spawn ? lanes_c : 4'h0;

    // State, address, lane accumulator and frame_clk history registers
    always_ff @(posedge Clk) begin
        if (reset) begin
            state       <= IDLE;
            rom_addr    <= '0;
            acc         <= 4'h0;
            frame_clk_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            rom_addr    <= addr_nxt;
            acc         <= acc_nxt;
            frame_clk_q <= frame_clk;
        end
    end

    // Song position: cleared on start, counts unpaused ticks while busy,
    // saturates one below the end-marker timestamp
    always_ff @(posedge Clk) begin
        if (reset) begin
            frame_count <= 12'h000;
        end else if (restart) begin
            frame_count <= 12'h000;
        end else if (tick_counted && (frame_count != FRAME_MAX)) begin
            frame_count <= frame_count + 12'd1;
        end
    end

    // Next-state, address/accumulator update and spawn decode
    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        acc_nxt   = acc;
        spawn_c   = 1'b0;
        lanes_c   = 4'h0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    addr_nxt  = '0;
                    acc_nxt   = 4'h0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                if (rom_data == END_WORD) begin
                    spawn_c   = (acc != 4'h0);
                    lanes_c   = acc;
                    acc_nxt   = 4'h0;
                    state_nxt = DONE;
                end else if (entry_ts <= frame_count) begin
                    // Due entry (including out-of-order earlier timestamps).
                    // The last ROM slot ends the chart instead of wrapping.
                    if (&rom_addr) begin
                        spawn_c   = (merged != 4'h0);
                        lanes_c   = merged;
                        acc_nxt   = 4'h0;
                        state_nxt = DONE;
                    end else begin
                        acc_nxt   = merged;
                        addr_nxt  = rom_addr + ROM_AW'(1);
                        state_nxt = FETCH;
                    end
                end else begin
                    spawn_c   = (acc != 4'h0);
                    lanes_c   = acc;
                    acc_nxt   = 4'h0;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (tick_counted) begin
                    state_nxt = CHECK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer: one 8-bit-address instance for the
// playback scenarios and one 2-bit-address instance for the no-wrap case.
module tb_chart_sequencer;

    logic        Clk;
    logic        reset;
    logic        frame_clk;
    logic        start;
    logic        start2;
    logic        pause;

    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        spawn;
    logic [3:0]  spawn_lanes;
    logic [11:0] frame_count;
    logic        busy;
    logic        done;

    logic [1:0]  rom_addr2;
    logic [15:0] rom_data2;
    logic        spawn2;
    logic [3:0]  spawn_lanes2;
    logic [11:0] frame_count2;
    logic        busy2;
    logic        done2;

    logic [15:0] mem  [0:255];
    logic [15:0] mem2 [0:3];

    int tests = 0;
    int fails = 0;
    int spawn_cnt = 0;
    int spawn_cnt2 = 0;
    int consec_err = 0;
    logic spawn_prev = 1'b0;
    logic spawn_prev2 = 1'b0;
    int base;

    chart_sequencer #(.ROM_AW(8), .END_WORD(16'hFFF0)) dut (
        .Clk(Clk), .reset(reset), .frame_clk(frame_clk), .start(start),
        .pause(pause), .rom_addr(rom_addr), .rom_data(rom_data),
        .spawn(spawn), .spawn_lanes(spawn_lanes), .frame_count(frame_count),
        .busy(busy), .done(done)
    );

    chart_sequencer #(.ROM_AW(2), .END_WORD(16'hFFF0)) dut2 (
        .Clk(Clk), .reset(reset), .frame_clk(frame_clk), .start(start2),
        .pause(pause), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .spawn(spawn2), .spawn_lanes(spawn_lanes2), .frame_count(frame_count2),
        .busy(busy2), .done(done2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous chart ROMs with one cycle of read latency
    always @(posedge Clk) begin
        rom_data  <= mem[rom_addr];
        rom_data2 <= mem2[rom_addr2];
    end

    // Spawn pulse monitor: counts pulses and flags back-to-back pulses
    always @(negedge Clk) begin
        if (spawn) begin
            spawn_cnt = spawn_cnt + 1;
            if (spawn_prev) consec_err = consec_err + 1;
        end
        if (spawn2) begin
            spawn_cnt2 = spawn_cnt2 + 1;
            if (spawn_prev2) consec_err = consec_err + 1;
        end
        spawn_prev  = spawn;
        spawn_prev2 = spawn2;
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        cyc();
        frame_clk = 1'b0;
        cyc();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp)
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; frame_clk = 1'b0; start = 1'b0; start2 = 1'b0; pause = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFF0;
        for (int i = 0; i < 4; i++) mem2[i] = 16'hFFF0;
        cyc(); cyc();
        reset = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fc", frame_count, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_spawn", spawn, 0);
        check("rst_lanes", spawn_lanes, 0);
        check("rst_busy2", busy2, 0);

        // Chart {ts0 m1, ts2 m8, END}
        mem[0] = 16'h0001; mem[1] = 16'h0028; mem[2] = 16'hFFF0;
        base = spawn_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        check("a_busy_fetch", busy, 1);
        cyc(); cyc(); cyc();
        check("a_spawn1", spawn, 1);
        check("a_lanes1", spawn_lanes, 4'h1);
        check("a_fc0", frame_count, 0);
        cyc();
        check("a_wait_nospawn", spawn, 0);
        check("a_wait_lanes0", spawn_lanes, 0);
        frame_pulse();
        check("a_fc1", frame_count, 1);
        frame_clk = 1'b1; cyc(); frame_clk = 1'b0;
        check("a_fc2", frame_count, 2);
        check("a_due_nospawn", spawn, 0);
        cyc(); cyc();
        check("a_spawn8", spawn, 1);
        check("a_lanes8", spawn_lanes, 4'h8);
        cyc();
        check("a_done", done, 1);
        check("a_busy_done", busy, 0);
        check("a_spawn_count", spawn_cnt - base, 2);
        frame_pulse();
        check("a_done_fc_hold", frame_count, 2);

        // Chart {ts5 m1, ts5 m2, ts5 m4, END}: one merged pulse
        mem[0] = 16'h0051; mem[1] = 16'h0052; mem[2] = 16'h0054; mem[3] = 16'hFFF0;
        base = spawn_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        check("b_restart_fc", frame_count, 0);
        cyc(); cyc();
        for (int i = 0; i < 4; i++) frame_pulse();
        check("b_fc4", frame_count, 4);
        check("b_no_early", spawn_cnt - base, 0);
        frame_clk = 1'b1; cyc(); frame_clk = 1'b0;
        check("b_fc5", frame_count, 5);
        for (int i = 0; i < 5; i++) cyc();
        check("b_premerge_nospawn", spawn_cnt - base, 0);
        cyc();
        check("b_spawn", spawn, 1);
        check("b_lanes7", spawn_lanes, 4'h7);
        cyc();
        check("b_done", done, 1);
        check("b_single", spawn_cnt - base, 1);

        // Same chart with three paused ticks while waiting
        base = spawn_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        frame_pulse(); frame_pulse();
        check("c_fc2", frame_count, 2);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) frame_pulse();
        check("c_paused_fc", frame_count, 2);
        check("c_paused_nospawn", spawn_cnt - base, 0);
        pause = 1'b0;
        frame_pulse(); frame_pulse();
        check("c_fc4_delayed", frame_count, 4);
        check("c_delayed_nospawn", spawn_cnt - base, 0);
        frame_pulse();
        for (int i = 0; i < 6; i++) cyc();
        check("c_spawn_count", spawn_cnt - base, 1);
        check("c_done", done, 1);
        check("c_fc5", frame_count, 5);

        // Entry 0 is the end marker; replay resets frame_count
        mem[0] = 16'hFFF0;
        base = spawn_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        check("d_fc_cleared", frame_count, 0);
        frame_clk = 1'b1; cyc(); frame_clk = 1'b0;
        check("d_fc1", frame_count, 1);
        check("d_check_busy", busy, 1);
        cyc();
        check("d_done", done, 1);
        start = 1'b1; cyc(); start = 1'b0;
        check("d_replay_fc0", frame_count, 0);
        check("d_replay_done0", done, 0);
        cyc(); cyc();
        check("d_replay_done", done, 1);
        check("d_nospawn", spawn_cnt - base, 0);

        // Reset in WAIT at frame 7; start while busy ignored
        mem[0] = 16'h0001; mem[1] = 16'h0641;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        for (int i = 0; i < 7; i++) frame_pulse();
        check("e_fc7", frame_count, 7);
        start = 1'b1; cyc(); start = 1'b0;
        check("e_ignored_addr", rom_addr, 1);
        check("e_ignored_fc", frame_count, 7);
        check("e_ignored_busy", busy, 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("e_rst_busy", busy, 0);
        check("e_rst_done", done, 0);
        check("e_rst_fc", frame_count, 0);
        check("e_rst_addr", rom_addr, 0);
        check("e_rst_spawn", spawn, 0);
        check("e_rst_lanes", spawn_lanes, 0);

        // Reset landing on a spawning CHECK cycle suppresses the pulse
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc(); cyc();
        check("f_pre_spawn", spawn, 1);
        reset = 1'b1; #1;
        check("f_rst_cycle_spawn", spawn, 0);
        cyc(); reset = 1'b0;
        check("f_after_spawn", spawn, 0);
        check("f_after_busy", busy, 0);

        // frame_count saturation while waiting on a never-due entry
        mem[0] = 16'hFFF1;
        base = spawn_cnt;
        start = 1'b1; cyc(); start = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 4100; i++) frame_pulse();
        check("g_fc_sat", frame_count, 12'hFFE);
        check("g_busy", busy, 1);
        check("g_nospawn", spawn_cnt - base, 0);
        reset = 1'b1; cyc(); reset = 1'b0;

        // ROM_AW=2, four due entries, no end marker
        mem2[0] = 16'h0001; mem2[1] = 16'h0002; mem2[2] = 16'h0004; mem2[3] = 16'h0008;
        start2 = 1'b1; cyc(); start2 = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        check("h_spawn", spawn2, 1);
        check("h_lanesF", spawn_lanes2, 4'hF);
        check("h_addr3", rom_addr2, 3);
        cyc();
        check("h_done", done2, 1);
        check("h_no_wrap", rom_addr2, 3);
        check("h_single", spawn_cnt2, 1);

        check("no_consecutive_spawn", consec_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
